// File: rtl/regdump_reader_pkg.sv
// Shared definitions for the register-file debug dump reader: FSM encoding,
// default geometry and the named registers with non-zero reset values.
package regdump_reader_pkg;

  localparam int unsigned NREGS_DEF  = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned DATA_W_DEF = 32;

  localparam int unsigned REG_GP = 28;
  localparam int unsigned REG_SP = 29;
  localparam int unsigned REG_RA = 31;

  localparam logic [31:0] GP_RESET = 32'h1000_8000;
  localparam logic [31:0] SP_RESET = 32'h7fff_effc;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_LATCH,
    S_CAPT,
    S_SEND
  } state_t;

endpackage

// File: rtl/regdump_reader_if.sv
// Valid/ready word stream carrying one dumped register (value, index, last flag).
interface regdump_reader_if
  import regdump_reader_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_idx;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    output out_data,
    output out_idx,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_idx,
    input  out_valid,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/regdump_reader.sv
// Walks the register file debug port (address + read strobe) over one register
// or the whole set and streams each captured word out on a valid/ready link.
module regdump_reader
  import regdump_reader_pkg::*;
#(
  parameter int unsigned NREGS  = NREGS_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              res,
  input  logic              start,
  input  logic              single,
  input  logic [ADDR_W-1:0] sel_addr,
  input  logic              abort,
  output logic [ADDR_W-1:0] radd_debug,
  output logic              clk_debug,
  input  logic [DATA_W-1:0] dout_debug,
  regdump_reader_if.master  stream,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

  state_t            state;
  logic [ADDR_W-1:0] cur;
  logic              mode;

  always_ff @(posedge clk) begin
    if (!res) begin
      state            <= S_IDLE;
      cur              <= '0;
      mode             <= 1'b0;
      radd_debug       <= '0;
      clk_debug        <= 1'b0;
      stream.out_data  <= '0;
      stream.out_idx   <= '0;
      stream.out_valid <= 1'b0;
      stream.out_last  <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      done <= 1'b0;
      // Abort wins over any in-flight step, including a pending handshake.
      if (abort && (state != S_IDLE)) begin
        state            <= S_IDLE;
        clk_debug        <= 1'b0;
        stream.out_valid <= 1'b0;
        busy             <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !abort) begin
              cur   <= single ? sel_addr : '0;
              mode  <= single;
              busy  <= 1'b1;
              state <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            radd_debug <= cur;
            clk_debug  <= 1'b1;
            state      <= S_LATCH;
          end
          S_LATCH: begin
            // Register file updates dout_debug on this falling strobe edge.
            clk_debug <= 1'b0;
            state     <= S_CAPT;
          end
          S_CAPT: begin
            stream.out_data  <= dout_debug;
            stream.out_idx   <= cur;
            stream.out_last  <= mode || (cur == LAST_IDX);
            stream.out_valid <= 1'b1;
            state            <= S_SEND;
          end
          S_SEND: begin
            if (stream.out_valid && stream.out_ready) begin
              stream.out_valid <= 1'b0;
              if (stream.out_last) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= S_IDLE;
              end else begin
                cur   <= cur + ADDR_W'(1);
                state <= S_ISSUE;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_regdump_reader.sv
// Bench for regdump_reader: a behavioural register file on the debug port and
// an expected-contents array predicting every word of each dump.
module tb_regdump_reader;
  import regdump_reader_pkg::*;

  localparam int NREGS  = 32;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              res;
  logic              start;
  logic              single;
  logic [ADDR_W-1:0] sel_addr;
  logic              abort;
  logic [ADDR_W-1:0] radd_debug;
  logic              clk_debug;
  logic [DATA_W-1:0] dout_debug;
  logic              busy;
  logic              done;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rf [NREGS];
  logic [DATA_W-1:0] exp_regs [NREGS];

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  regdump_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) st ();

  regdump_reader #(.NREGS(NREGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .res(res), .start(start), .single(single), .sel_addr(sel_addr),
    .abort(abort), .radd_debug(radd_debug), .clk_debug(clk_debug),
    .dout_debug(dout_debug), .stream(st), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file: reset values, synchronous write port, debug read on falling strobe.
  always @(posedge clk) begin
    if (!res) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
      rf[REG_GP] <= GP_RESET;
      rf[REG_SP] <= SP_RESET;
    end else if (we) begin
      rf[waddr] <= wdata;
    end
  end
  always @(negedge clk_debug) dout_debug <= rf[radd_debug];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) exp_regs[i] = '0;
    exp_regs[REG_GP] = GP_RESET;
    exp_regs[REG_SP] = SP_RESET;
  endtask

  task automatic apply_reset();
    res = 1'b0; start = 1'b0; single = 1'b0; sel_addr = '0; abort = 1'b0;
    we = 1'b0; st.out_ready = 1'b1;
    tick(); tick();
    res = 1'b1;
    tick();
    model_reset();
  endtask

  task automatic write_reg(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    we = 1'b1; waddr = a; wdata = d;
    tick();
    we = 1'b0;
    exp_regs[a] = d;
  endtask

  task automatic randomize_regs();
    for (int i = 0; i < NREGS; i++) write_reg(ADDR_W'(i), DATA_W'($urandom));
  endtask

  task automatic pulse_start(input logic sg, input logic [ADDR_W-1:0] a, output int s);
    start = 1'b1; single = sg; sel_addr = a;
    s = cyc + 1;
    tick();
    start = 1'b0; single = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    int n;
    n = 0;
    while (st.out_valid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    ok = (st.out_valid === 1'b1);
  endtask

  task automatic test_reset();
    logic [ADDR_W+DATA_W+ADDR_W+6-1:0] got;
    res = 1'b0; start = 1'b0; abort = 1'b0; we = 1'b0; st.out_ready = 1'b1;
    tick(); tick();
    got = {radd_debug, clk_debug, st.out_data, st.out_idx, st.out_valid, st.out_last, busy, done};
    n_cmp++;
    if (got !== '0) begin
      n_err++; $display("FAIL reset_outputs got %h want 0", got);
    end
    res = 1'b1;
    tick();
    model_reset();
  endtask

  task automatic test_full_reset_dump();
    int s, hs;
    bit ok;
    apply_reset();
    hs = 0;
    pulse_start(1'b0, '0, s);
    for (int i = 0; i < NREGS; i++) begin
      wait_valid(20, ok);
      n_cmp++;
      if (!ok) begin
        n_err++; $display("FAIL full_timeout word %0d got no valid want valid", i); return;
      end
      n_cmp++;
      if ({st.out_idx, st.out_data, st.out_last} !== {ADDR_W'(i), exp_regs[i], (i == NREGS - 1)}) begin
        n_err++;
        $display("FAIL full_word %0d got idx=%0d data=%h last=%b want idx=%0d data=%h last=%b",
                 i, st.out_idx, st.out_data, st.out_last, i, exp_regs[i], (i == NREGS - 1));
      end
      if (i == NREGS - 1) hs = cyc + 1;
      tick();
    end
    n_cmp++;
    if (hs - s != 4 * NREGS) begin
      n_err++; $display("FAIL full_cycles got %0d want %0d", hs - s, 4 * NREGS);
    end
    n_cmp++;
    if ({done, busy, st.out_valid} !== 3'b100) begin
      n_err++; $display("FAIL full_done got done/busy/valid=%b want 100", {done, busy, st.out_valid});
    end
    tick();
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++; $display("FAIL full_done_pulse got %b want 0", done);
    end
  endtask

  task automatic test_single();
    int s, first;
    logic [ADDR_W-1:0] a;
    bit ok;
    apply_reset();
    write_reg(ADDR_W'(REG_RA), 32'hDEAD_BEEF);
    pulse_start(1'b1, ADDR_W'(REG_RA), s);
    first = -1;
    for (int n = 0; n < 10 && first < 0; n++) begin
      if (st.out_valid === 1'b1) first = cyc;
      else tick();
    end
    n_cmp++;
    if (first - s != 3) begin
      n_err++; $display("FAIL single_latency got %0d want 3", first - s);
    end
    n_cmp++;
    if ({st.out_idx, st.out_data, st.out_last} !== {ADDR_W'(REG_RA), 32'hDEAD_BEEF, 1'b1}) begin
      n_err++; $display("FAIL single_word got idx=%0d data=%h last=%b want idx=31 data=deadbeef last=1",
                        st.out_idx, st.out_data, st.out_last);
    end
    tick();
    n_cmp++;
    if ({done, busy} !== 2'b10) begin
      n_err++; $display("FAIL single_done got done/busy=%b want 10", {done, busy});
    end
    for (int k = 0; k < 8; k++) begin
      a = ADDR_W'($urandom_range(0, NREGS - 1));
      write_reg(a, DATA_W'($urandom));
      pulse_start(1'b1, a, s);
      wait_valid(10, ok);
      n_cmp++;
      if (!ok || {st.out_idx, st.out_data, st.out_last} !== {a, exp_regs[a], 1'b1}) begin
        n_err++; $display("FAIL single_rand got idx=%0d data=%h last=%b want idx=%0d data=%h last=1",
                          st.out_idx, st.out_data, st.out_last, a, exp_regs[a]);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int s, stall;
    bit ok, last;
    apply_reset();
    randomize_regs();
    pulse_start(1'b0, '0, s);
    for (int i = 0; i < NREGS; i++) begin
      wait_valid(20, ok);
      if (!ok) begin
        n_cmp++; n_err++; $display("FAIL bp_timeout word %0d got no valid want valid", i); return;
      end
      last = (i == NREGS - 1);
      stall = (i == 5) ? 10 : int'($urandom_range(0, 2));
      st.out_ready = 1'b0;
      for (int c = 0; c <= stall; c++) begin
        n_cmp++;
        if ({st.out_data, st.out_idx, st.out_valid, st.out_last, clk_debug} !==
            {exp_regs[i], ADDR_W'(i), 1'b1, last, 1'b0}) begin
          n_err++;
          $display("FAIL bp_hold word %0d cyc %0d got data=%h idx=%0d v=%b l=%b sclk=%b want data=%h idx=%0d v=1 l=%b sclk=0",
                   i, c, st.out_data, st.out_idx, st.out_valid, st.out_last, clk_debug, exp_regs[i], i, last);
        end
        if (c < stall) tick();
      end
      st.out_ready = 1'b1;
      tick();
    end
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++; $display("FAIL bp_done got %b want 1", done);
    end
  endtask

  task automatic test_abort();
    int s;
    bit ok, bad;
    apply_reset();
    randomize_regs();
    pulse_start(1'b0, '0, s);
    for (int i = 0; i <= 12; i++) begin
      wait_valid(20, ok);
      if (!ok) begin
        n_cmp++; n_err++; $display("FAIL abort_timeout word %0d got no valid want valid", i); return;
      end
      if (i < 12) tick();
    end
    st.out_ready = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0; st.out_ready = 1'b1;
    n_cmp++;
    if ({st.out_valid, busy, done, clk_debug} !== 4'b0000) begin
      n_err++; $display("FAIL abort_send got valid/busy/done/sclk=%b want 0000", {st.out_valid, busy, done, clk_debug});
    end
    bad = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (done !== 1'b0 || st.out_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin
      n_err++; $display("FAIL abort_quiet got activity after abort want idle");
    end
    pulse_start(1'b0, '0, s);
    wait_valid(10, ok);
    n_cmp++;
    if (!ok || {st.out_idx, st.out_data} !== {ADDR_W'(0), exp_regs[0]}) begin
      n_err++; $display("FAIL abort_restart got idx=%0d data=%h want idx=0 data=%h", st.out_idx, st.out_data, exp_regs[0]);
    end
    tick();
    tick();
    n_cmp++;
    if (clk_debug !== 1'b1) begin
      n_err++; $display("FAIL abort_latch_pre got sclk=%b want 1", clk_debug);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++;
    if ({clk_debug, busy, st.out_valid, done} !== 4'b0000) begin
      n_err++; $display("FAIL abort_latch got sclk/busy/valid/done=%b want 0000", {clk_debug, busy, st.out_valid, done});
    end
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    tick();
    n_cmp++;
    if ({busy, clk_debug} !== 2'b00) begin
      n_err++; $display("FAIL abort_with_start got busy/sclk=%b want 00", {busy, clk_debug});
    end
  endtask

  task automatic test_reset_mid();
    int s;
    bit ok, bad;
    logic [ADDR_W+DATA_W+ADDR_W+6-1:0] got;
    apply_reset();
    randomize_regs();
    write_reg(ADDR_W'(28), 32'hA5A5_0001);
    pulse_start(1'b0, '0, s);
    for (int i = 0; i <= 28; i++) begin
      wait_valid(20, ok);
      if (!ok) begin
        n_cmp++; n_err++; $display("FAIL rmid_timeout word %0d got no valid want valid", i); return;
      end
      tick();
    end
    tick();
    n_cmp++;
    if (clk_debug !== 1'b1 || st.out_data !== 32'hA5A5_0001) begin
      n_err++; $display("FAIL rmid_pre got sclk=%b data=%h want sclk=1 data=a5a50001", clk_debug, st.out_data);
    end
    res = 1'b0; start = 1'b1;
    tick();
    got = {radd_debug, clk_debug, st.out_data, st.out_idx, st.out_valid, st.out_last, busy, done};
    n_cmp++;
    if (got !== '0) begin
      n_err++; $display("FAIL rmid_outputs got %h want 0", got);
    end
    bad = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (busy !== 1'b0 || clk_debug !== 1'b0) bad = 1'b1;
    end
    res = 1'b1; start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (busy !== 1'b0 || st.out_valid !== 1'b0) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin
      n_err++; $display("FAIL rmid_start_ignored got busy during reset want idle");
    end
    model_reset();
  endtask

  task automatic test_start_busy();
    int s;
    bit ok, extra;
    apply_reset();
    randomize_regs();
    pulse_start(1'b0, '0, s);
    for (int i = 0; i < NREGS; i++) begin
      wait_valid(20, ok);
      if (!ok) begin
        n_cmp++; n_err++; $display("FAIL busy_timeout word %0d got no valid want valid", i); return;
      end
      n_cmp++;
      if ({st.out_idx, st.out_data, st.out_last} !== {ADDR_W'(i), exp_regs[i], (i == NREGS - 1)}) begin
        n_err++;
        $display("FAIL busy_word %0d got idx=%0d data=%h last=%b want idx=%0d data=%h last=%b",
                 i, st.out_idx, st.out_data, st.out_last, i, exp_regs[i], (i == NREGS - 1));
      end
      if (i == 4) begin
        start = 1'b1; single = 1'b1; sel_addr = ADDR_W'(3);
        tick();
        tick();
        start = 1'b0; single = 1'b0;
      end else begin
        if ($urandom_range(0, 1) == 1) begin
          st.out_ready = 1'b0;
          tick();
          st.out_ready = 1'b1;
        end
        tick();
      end
    end
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++; $display("FAIL busy_done got %b want 1", done);
    end
    extra = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (st.out_valid !== 1'b0 || busy !== 1'b0) extra = 1'b1;
    end
    n_cmp++;
    if (extra) begin
      n_err++; $display("FAIL busy_extra_word got activity after done want idle");
    end
  endtask

  initial begin
    start = 1'b0; single = 1'b0; sel_addr = '0; abort = 1'b0; res = 1'b0;
    we = 1'b0; waddr = '0; wdata = '0; st.out_ready = 1'b1;
    test_reset();
    test_full_reset_dump();
    test_single();
    test_backpressure();
    test_abort();
    test_reset_mid();
    test_start_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got no completion want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
